// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared op codes, flag bit positions and op-class helper
//                for the pipelined ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_ADDC = 3'b100,
        OP_SLT  = 3'b101,
        OP_NOR  = 3'b110,
        OP_XOR  = 3'b111
    } op_e;

    // Bit positions inside the 4-bit {ovf, carry, neg, zero} flag vector.
    localparam int C_FLAG_ZERO  = 0;
    localparam int C_FLAG_NEG   = 1;
    localparam int C_FLAG_CARRY = 2;
    localparam int C_FLAG_OVF   = 3;
    localparam int C_FLAG_W     = 4;

    function automatic logic is_arith(input op_e op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADDC);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
//  Module      : alu_core
//  Description : Combinational ALU datapath: op decode, shared adder,
//                logic unit and flag generation.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]          i_op,
    input  logic [WIDTH-1:0]    i_a,
    input  logic [WIDTH-1:0]    i_b,
    input  logic                i_carry,
    output logic [WIDTH-1:0]    o_result,
    output logic [C_FLAG_W-1:0] o_flags,
    output logic                o_carry,
    output logic                o_carry_upd
);

    op_e              w_op;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_cin;
    logic [WIDTH:0]   w_sum;
    logic             w_slt;
    logic [WIDTH-1:0] w_res;
    logic             w_carry;
    logic             w_ovf;

    assign w_op = op_e'(i_op);

    // ADD, SUB and ADDC all share one adder; SUB is a + ~b + 1.
    always_comb begin
        w_b_eff = i_b;
        w_cin   = 1'b0;
        case (w_op)
            OP_SUB: begin
                w_b_eff = ~i_b;
                w_cin   = 1'b1;
            end
            OP_ADDC: w_cin = i_carry;
            default: w_cin = 1'b0;
        endcase
    end

    assign w_sum = {1'b0, i_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_cin};

    // Direct signed compare avoids the overflow pitfall of sign-of-difference.
    assign w_slt = ($signed(i_a) < $signed(i_b));

    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        case (w_op)
            OP_AND: w_res = i_a & i_b;
            OP_OR:  w_res = i_a | i_b;
            OP_NOR: w_res = ~(i_a | i_b);
            OP_XOR: w_res = i_a ^ i_b;
            OP_SLT: w_res = {{(WIDTH-1){1'b0}}, w_slt};
            OP_ADD, OP_SUB, OP_ADDC: begin
                w_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
                w_ovf   = (i_a[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                          (w_sum[WIDTH-1] != i_a[WIDTH-1]);
            end
            default: w_res = '0;
        endcase
    end

    always_comb begin
        o_flags               = '0;
        o_flags[C_FLAG_ZERO]  = (w_res == '0);
        o_flags[C_FLAG_NEG]   = w_res[WIDTH-1];
        o_flags[C_FLAG_CARRY] = w_carry;
        o_flags[C_FLAG_OVF]   = w_ovf;
    end

    assign o_result    = w_res;
    assign o_carry     = w_carry;
    assign o_carry_upd = is_arith(w_op);

endmodule

`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pipe
//  Description : Two-stage valid/ready pipelined ALU (S1 operands, S2 result)
//                with a carry register feeding ADDC.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    generate
        if (WIDTH < 4 || WIDTH > 64) begin : g_bad_width
            $error("alu_pipe: WIDTH must be within 4..64");
        end
    endgenerate

    logic                r_s1_valid;
    logic [2:0]          r_s1_op;
    logic [WIDTH-1:0]    r_s1_a;
    logic [WIDTH-1:0]    r_s1_b;

    logic                r_s2_valid;
    logic [WIDTH-1:0]    r_result;
    logic [C_FLAG_W-1:0] r_flags;
    logic                r_carry_q;

    logic                w_s2_load;
    logic                w_s1_adv;
    logic                w_in_ready;
    logic                w_accept;
    logic [WIDTH-1:0]    w_result;
    logic [C_FLAG_W-1:0] w_flags;
    logic                w_carry;
    logic                w_carry_upd;

    assign w_s2_load  = !r_s2_valid || out_ready;
    assign w_s1_adv   = r_s1_valid && w_s2_load;
    // Gated by reset so nothing is accepted while the pipe is being flushed.
    assign w_in_ready = !reset && (!r_s1_valid || w_s1_adv);
    assign w_accept   = in_valid && w_in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= '0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_op    <= op;
            r_s1_a     <= a;
            r_s1_b     <= b;
        end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    alu_core #(
        .WIDTH       (WIDTH)
    ) u_core (
        .i_op        (r_s1_op),
        .i_a         (r_s1_a),
        .i_b         (r_s1_b),
        .i_carry     (r_carry_q),
        .o_result    (w_result),
        .o_flags     (w_flags),
        .o_carry     (w_carry),
        .o_carry_upd (w_carry_upd)
    );

    // carry_q moves with the op into S2, so a following ADDC in S1 sees it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s2_valid <= 1'b0;
            r_result   <= '0;
            r_flags    <= '0;
            r_carry_q  <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_result <= w_result;
                r_flags  <= w_flags;
                if (w_carry_upd) begin
                    r_carry_q <= w_carry;
                end
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_s2_valid;
    assign result    = r_result;
    assign flags     = r_flags;

endmodule

`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_pipe
//  Description : Directed self-checking bench for alu_pipe (WIDTH=32).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_pipe;

    localparam int W = 32;
    localparam logic [2:0] C_OP_AND  = 3'b000;
    localparam logic [2:0] C_OP_OR   = 3'b001;
    localparam logic [2:0] C_OP_ADD  = 3'b010;
    localparam logic [2:0] C_OP_SUB  = 3'b011;
    localparam logic [2:0] C_OP_ADDC = 3'b100;
    localparam logic [2:0] C_OP_SLT  = 3'b101;
    localparam logic [2:0] C_OP_NOR  = 3'b110;
    localparam logic [2:0] C_OP_XOR  = 3'b111;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [3:0]   flags;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_pipe #(
        .WIDTH     (W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    // Presents one op and holds it until accepted; returns just after the accepting edge.
    task automatic send(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output int waits);
        bit done;
        done  = 1'b0;
        waits = 0;
        in_valid = 1'b1; op = o; a = x; b = y;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk); #1;
            if (in_ready === 1'b1) done = 1'b1;
            else waits++;
            @(posedge clk); #1;
        end
        if (!done) begin
            n_checks++; n_fail++;
            $display("FAIL send_timeout: op %b never accepted, in_ready=%b required 1", o, in_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = '0; a = '0; b = '0;
        #1 reset = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (result !== '0) begin n_fail++; $display("FAIL rst_result: got %h expected 0", result); end
        n_checks++; if (flags !== 4'b0000) begin n_fail++; $display("FAIL rst_flags: got %b expected 0000", flags); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
        reset = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_in_ready: got %b expected 1", in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_add_wrap();
        int w;
        send(C_OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, w);
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_latency_early: out_valid got %b expected 0", out_valid); end
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL add_latency: out_valid got %b expected 1", out_valid); end
        n_checks++; if (result !== 32'h0000_0000) begin n_fail++; $display("FAIL add_wrap_result: got %h expected 00000000", result); end
        n_checks++; if (flags !== 4'b0101) begin n_fail++; $display("FAIL add_wrap_flags: got %b expected 0101", flags); end
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_no_dup: out_valid got %b expected 0", out_valid); end
    endtask

    task automatic test_addc_chain();
        int w;
        send(C_OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, w);
        send(C_OP_ADDC, 32'h0, 32'h0, w);
        in_valid = 1'b0;
        n_checks++; if (result !== 32'h0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL chain_add: result %h valid %b expected 00000000/1", result, out_valid); end
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL chain_addc_valid: got %b expected 1", out_valid); end
        n_checks++; if (result !== 32'h0000_0001) begin n_fail++; $display("FAIL chain_addc_result: got %h expected 00000001", result); end
        n_checks++; if (flags !== 4'b0000) begin n_fail++; $display("FAIL chain_addc_flags: got %b expected 0000", flags); end
        @(posedge clk); #1;
    endtask

    task automatic test_sub_slt();
        logic [2:0]   v_op [3];
        logic [W-1:0] v_a  [3];
        logic [W-1:0] v_b  [3];
        logic [W-1:0] e_r  [3];
        logic [3:0]   e_f  [3];
        v_op = '{C_OP_SUB, C_OP_SLT, C_OP_SUB};
        v_a  = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0005};
        v_b  = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0005};
        e_r  = '{32'h8000_0000, 32'h0000_0001, 32'h0000_0000};
        e_f  = '{4'b1010, 4'b0000, 4'b0101};
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin
                in_valid = 1'b1; op = v_op[i]; a = v_a[i]; b = v_b[i];
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            if (i > 0) begin
                n_checks++;
                if (out_valid !== 1'b1 || result !== e_r[i-1] || flags !== e_f[i-1]) begin
                    n_fail++;
                    $display("FAIL sub_slt[%0d]: valid %b result %h flags %b expected 1/%h/%b",
                             i-1, out_valid, result, flags, e_r[i-1], e_f[i-1]);
                end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_logic();
        logic [2:0]   v_op [5];
        logic [W-1:0] v_a  [5];
        logic [W-1:0] v_b  [5];
        logic [W-1:0] e_r  [5];
        logic [3:0]   e_f  [5];
        v_op = '{C_OP_AND, C_OP_OR, C_OP_NOR, C_OP_XOR, C_OP_SLT};
        v_a  = '{32'hF0F0_1234, 32'hF0F0_1234, 32'hF0F0_1234, 32'hF0F0_1234, 32'h0000_0001};
        v_b  = '{32'h0FF0_FF00, 32'h0FF0_FF00, 32'h0FF0_FF00, 32'h0FF0_FF00, 32'h8000_0000};
        e_r  = '{32'h00F0_1200, 32'hFFF0_FF34, 32'h000F_00CB, 32'hFF00_ED34, 32'h0000_0000};
        e_f  = '{4'b0000, 4'b0010, 4'b0000, 4'b0010, 4'b0001};
        for (int i = 0; i < 6; i++) begin
            if (i < 5) begin
                in_valid = 1'b1; op = v_op[i]; a = v_a[i]; b = v_b[i];
                #1;
                n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL logic_in_ready[%0d]: got %b expected 1", i, in_ready); end
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            if (i > 0) begin
                n_checks++;
                if (out_valid !== 1'b1 || result !== e_r[i-1] || flags !== e_f[i-1]) begin
                    n_fail++;
                    $display("FAIL logic[%0d]: valid %b result %h flags %b expected 1/%h/%b",
                             i-1, out_valid, result, flags, e_r[i-1], e_f[i-1]);
                end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back_stall();
        int total_waits;
        int got;
        total_waits = 0;
        got         = 0;
        out_ready   = 1'b1;
        fork
            begin : tx
                int w;
                for (int i = 0; i < 4; i++) begin
                    send(C_OP_ADD, W'(i), 32'h0000_0100, w);
                    total_waits += w;
                end
                in_valid = 1'b0;
            end
            begin : rx
                int stall;
                bit stalled;
                logic [W-1:0] held_r;
                logic [3:0]   held_f;
                stall = 0; stalled = 1'b0; held_r = '0; held_f = '0;
                for (int cyc = 0; cyc < 60 && got < 4; cyc++) begin
                    @(negedge clk);
                    if (out_valid === 1'b1 && !stalled) begin
                        stalled = 1'b1; stall = 3; out_ready = 1'b0;
                        held_r = result; held_f = flags;
                    end else if (stall > 0) begin
                        n_checks++;
                        if (out_valid !== 1'b1 || result !== held_r || flags !== held_f) begin
                            n_fail++;
                            $display("FAIL stall_hold: valid %b result %h flags %b expected 1/%h/%b",
                                     out_valid, result, flags, held_r, held_f);
                        end
                        stall--;
                        if (stall == 0) out_ready = 1'b1;
                    end
                    if (out_valid === 1'b1 && out_ready === 1'b1) begin
                        n_checks++;
                        if (result !== (32'h0000_0100 + W'(got)) || flags !== 4'b0000) begin
                            n_fail++;
                            $display("FAIL stream_order[%0d]: result %h flags %b expected %h/0000",
                                     got, result, flags, 32'h0000_0100 + W'(got));
                        end
                        got++;
                    end
                end
            end
        join
        n_checks++; if (got != 4) begin n_fail++; $display("FAIL stream_count: got %0d results expected 4", got); end
        n_checks++; if (total_waits == 0) begin n_fail++; $display("FAIL stream_backpressure: in_ready wait cycles %0d expected >0", total_waits); end
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_no_extra: out_valid got %b expected 0", out_valid); end
    endtask

    task automatic test_reset_inflight();
        int w;
        bit seen;
        out_ready = 1'b1;
        send(C_OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, w);
        send(C_OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, w);
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL inflight_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (result !== '0 || flags !== 4'b0000) begin n_fail++; $display("FAIL inflight_clear: result %h flags %b expected 0/0000", result, flags); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL inflight_in_ready: got %b expected 0", in_ready); end
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        n_checks++; if (seen) begin n_fail++; $display("FAIL inflight_discard: out_valid seen 1 expected 0"); end
        send(C_OP_ADDC, 32'h0000_0001, 32'h0000_0001, w);
        in_valid = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b1 || result !== 32'h0000_0002 || flags !== 4'b0000) begin
            n_fail++;
            $display("FAIL post_reset_addc: valid %b result %h flags %b expected 1/00000002/0000",
                     out_valid, result, flags);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add_wrap();
        test_addc_chain();
        test_sub_slt();
        test_logic();
        test_back_to_back_stall();
        test_reset_inflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
